// File: rtl/aes_key_expand_iter.sv
// aes_key_expand_iter
//   Iterative AES-128/192/256 key expander. Produces one 32-bit schedule word
//   per clock through a single shared 4-sbox SubWord unit. Groups of four
//   words are streamed out as 128-bit round keys over a valid/ready handshake.
//
//   Optional feature macro: AES_KEY_STORE_EN
//     When defined, every round key is also written to a 15-entry store.
//     The store is read back through rd_idx/rd_key with one cycle of latency.
//     When undefined, there is no store and rd_key is held at zero.
//
// Ports
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   start     : request pulse, sampled only while idle
//   key_len   : 0=AES-128, 1=AES-192, 2=AES-256
//   key       : cipher key, left-aligned (w0 in the top 32 bits)
//   busy      : expansion in progress
//   err       : one-cycle pulse on an illegal key_len at start
//   rk_valid  : rk_data/rk_idx/rk_last valid
//   rk_ready  : consumer accepts on rk_valid && rk_ready
//   rk_data   : round key {w4r, w4r+1, w4r+2, w4r+3}
//   rk_idx    : round index
//   rk_last   : high with the final round key
//   rd_idx    : store read index
//   rd_key    : stored round key (registered)
module aes_key_expand_iter #(
  parameter int MAX_NK = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            key_len,
  input  logic [32*MAX_NK-1:0]  key,
  output logic                  busy,
  output logic                  err,
  output logic                  rk_valid,
  input  logic                  rk_ready,
  output logic [127:0]          rk_data,
  output logic [3:0]            rk_idx,
  output logic                  rk_last,
  input  logic [3:0]            rd_idx,
  output logic [127:0]          rd_key
);

  typedef enum logic [1:0] {S_IDLE, S_GEN, S_DRAIN} state_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int n = 0; n < 8; n++) begin
      if (b[n]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Sbox as multiplicative inverse (x^254) followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int n = 1; n < 8; n++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  state_t        r_state;
  logic          r_busy;
  logic          r_err;
  logic          r_rk_valid;
  logic [127:0]  r_rk_data;
  logic [3:0]    r_rk_idx;
  logic          r_rk_last;
  logic [3:0]    r_nk;
  logic [5:0]    r_i;
  logic [2:0]    r_mod;
  logic [1:0]    r_wcnt;
  logic [7:0]    r_rcon;
  logic [3:0]    r_ridx;
  logic [31:0]   r_win [MAX_NK];
  logic [31:0]   r_buf [3];

  logic [31:0]   w_kw [MAX_NK];
  logic [3:0]    w_nk_req;
  logic          w_illegal;
  logic          w_accept_start;
  logic [31:0]   w_oldest;
  logic [31:0]   w_newest;
  logic [31:0]   w_sub_in;
  logic [31:0]   w_sub;
  logic [31:0]   w_t;
  logic [31:0]   w_word;
  logic [3:0]    w_nr;
  logic [5:0]    w_last_i;
  logic          w_stall;
  logic          w_produce;
  logic          w_load;
  logic          w_accept;
  logic [127:0]  w_rk_new;

  for (genvar g = 0; g < MAX_NK; g++) begin : g_kw
    assign w_kw[g] = key[32*MAX_NK-1-32*g -: 32];
  end

  always_comb begin
    case (key_len)
      2'd0:    w_nk_req = 4'd4;
      2'd1:    w_nk_req = 4'd6;
      2'd2:    w_nk_req = 4'd8;
      default: w_nk_req = 4'd0;
    endcase
  end

  assign w_illegal      = (key_len == 2'd3) || (int'(w_nk_req) > MAX_NK);
  assign w_accept_start = (r_state == S_IDLE) && start && !w_illegal;

  // Window: r_win[0] holds w[i-1], r_win[Nk-1] holds w[i-Nk].
  always_comb begin
    w_oldest = r_win[0];
    for (int k = 0; k < MAX_NK; k++)
      if (k == int'(r_nk) - 1) w_oldest = r_win[k];
  end
  assign w_newest = r_win[0];

  // One SubWord unit shared by the RotWord and the AES-256 mid-block cases.
  assign w_sub_in = (r_mod == 3'd0) ? {w_newest[23:0], w_newest[31:24]} : w_newest;
  assign w_sub    = subword(w_sub_in);

  always_comb begin
    if (r_mod == 3'd0)
      w_t = w_sub ^ {r_rcon, 24'h0};
    else if (r_nk == 4'd8 && r_mod == 3'd4)
      w_t = w_sub;
    else
      w_t = w_newest;
  end

  // While i < Nk the window rotates, replaying the key words unchanged.
  assign w_word    = (r_i < {2'b00, r_nk}) ? w_oldest : (w_oldest ^ w_t);
  assign w_nr      = r_nk + 4'd6;
  assign w_last_i  = {r_nk, 2'b00} + 6'd27;
  assign w_accept  = r_rk_valid && rk_ready;
  assign w_stall   = (r_wcnt == 2'd3) && r_rk_valid && !rk_ready;
  assign w_produce = (r_state == S_GEN) && !w_stall;
  assign w_load    = w_produce && (r_wcnt == 2'd3);
  assign w_rk_new  = {r_buf[0], r_buf[1], r_buf[2], w_word};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
      r_rk_valid <= 1'b0;
      r_rk_data  <= '0;
      r_rk_idx   <= '0;
      r_rk_last  <= 1'b0;
      r_rcon     <= 8'h01;
      r_nk       <= 4'd4;
      r_i        <= '0;
      r_mod      <= '0;
      r_wcnt     <= '0;
      r_ridx     <= '0;
    end else begin
      r_err <= 1'b0;
      if (w_accept) r_rk_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && w_illegal) begin
            r_err <= 1'b1;
          end else if (w_accept_start) begin
            r_nk    <= w_nk_req;
            r_i     <= '0;
            r_mod   <= '0;
            r_wcnt  <= '0;
            r_ridx  <= '0;
            r_rcon  <= 8'h01;
            r_busy  <= 1'b1;
            r_state <= S_GEN;
          end
        end
        S_GEN: begin
          if (w_produce) begin
            r_i <= r_i + 6'd1;
            if ({1'b0, r_mod} == r_nk - 4'd1) r_mod <= '0;
            else                              r_mod <= r_mod + 3'd1;
            if (r_i >= {2'b00, r_nk} && r_mod == 3'd0) r_rcon <= xtime(r_rcon);
            r_wcnt <= r_wcnt + 2'd1;
            if (w_load) begin
              r_rk_valid <= 1'b1;
              r_rk_data  <= w_rk_new;
              r_rk_idx   <= r_ridx;
              r_rk_last  <= (r_ridx == w_nr);
              r_ridx     <= r_ridx + 4'd1;
              if (r_i == w_last_i) r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (w_accept) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Datapath state: no reset needed, always loaded before use.
  always_ff @(posedge clk) begin
    if (w_accept_start) begin
      for (int k = 0; k < MAX_NK; k++)
        for (int j = 0; j < MAX_NK; j++)
          if (k < int'(w_nk_req) && j == int'(w_nk_req) - 1 - k) r_win[k] <= w_kw[j];
    end else if (w_produce) begin
      for (int k = 1; k < MAX_NK; k++) r_win[k] <= r_win[k-1];
      r_win[0] <= w_word;
      for (int k = 0; k < 3; k++)
        if (r_wcnt == 2'(k)) r_buf[k] <= w_word;
    end
  end

  assign busy     = r_busy;
  assign err      = r_err;
  assign rk_valid = r_rk_valid;
  assign rk_data  = r_rk_data;
  assign rk_idx   = r_rk_idx;
  assign rk_last  = r_rk_last;

`ifdef AES_KEY_STORE_EN
  logic [127:0] r_store [15];
  logic [127:0] r_rd_key;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 15; k++) r_store[k] <= '0;
      r_rd_key <= '0;
    end else begin
      if (w_load)
        for (int k = 0; k < 15; k++)
          if (r_ridx == 4'(k)) r_store[k] <= w_rk_new;
      r_rd_key <= '0;
      for (int k = 0; k < 15; k++)
        if (rd_idx == 4'(k)) r_rd_key <= r_store[k];
    end
  end

  assign rd_key = r_rd_key;
`else
  logic w_unused_rd;
  assign w_unused_rd = ^rd_idx;
  assign rd_key      = '0;
`endif

endmodule

// File: tb/tb_aes_key_expand_iter.sv
// Testbench for aes_key_expand_iter: scoreboard of expected round keys fed
// by a FIPS-197 style reference model, monitor popping on each handshake.
module tb_aes_key_expand_iter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   key_len = 2'd0;
  logic [255:0] key = '0;
  logic         busy;
  logic         err;
  logic         rk_valid;
  logic         rk_ready = 1'b1;
  logic [127:0] rk_data;
  logic [3:0]   rk_idx;
  logic         rk_last;
  logic [3:0]   rd_idx = 4'd0;
  logic [127:0] rd_key;

  aes_key_expand_iter #(.MAX_NK(8)) dut (
    .clk(clk), .rst(rst), .start(start), .key_len(key_len), .key(key),
    .busy(busy), .err(err), .rk_valid(rk_valid), .rk_ready(rk_ready),
    .rk_data(rk_data), .rk_idx(rk_idx), .rk_last(rk_last),
    .rd_idx(rd_idx), .rd_key(rd_key)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [127:0] data;
    logic [3:0]   idx;
    logic         last;
  } rk_t;

  rk_t          exp_q[$];
  logic [127:0] last_rk [15];
  logic [7:0]   sbox_t [256];
  int           n_cmp = 0;
  int           n_fail = 0;
  bit           rand_ready = 1'b0;

  task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Sbox from log/antilog tables over generator 3, then the bitwise affine map.
  task automatic build_sbox();
    logic [7:0] ex [256];
    int         lg [256];
    logic [7:0] v;
    logic [7:0] inv;
    logic [7:0] c;
    logic [7:0] s;
    c = 8'h63;
    v = 8'h01;
    for (int k = 0; k < 255; k++) begin
      ex[k] = v;
      lg[v] = k;
      v = v ^ xt(v);
    end
    for (int x = 0; x < 256; x++) begin
      inv = (x == 0) ? 8'h00 : ex[(255 - lg[x]) % 255];
      for (int b = 0; b < 8; b++)
        s[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ c[b];
      sbox_t[x] = s;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  function automatic logic [7:0] rcon_of(input int j);
    logic [7:0] r;
    r = 8'h01;
    for (int n = 1; n < j; n++) r = xt(r);
    return r;
  endfunction

  task automatic model_push(input int nk, input logic [255:0] k);
    logic [31:0] w [60];
    logic [31:0] tmp;
    rk_t         e;
    int          nr;
    nr = nk + 6;
    for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0)
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rcon_of(i/nk), 24'h0};
      else if (nk > 6 && i % nk == 4)
        tmp = subw(tmp);
      w[i] = w[i-nk] ^ tmp;
    end
    for (int r = 0; r <= nr; r++) begin
      e.data = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      e.idx  = 4'(r);
      e.last = (r == nr);
      last_rk[r] = e.data;
      exp_q.push_back(e);
    end
  endtask

  function automatic logic [255:0] rkey();
    logic [255:0] r;
    for (int n = 0; n < 8; n++) r[32*n +: 32] = $urandom;
    return r;
  endfunction

  task automatic do_start(input logic [1:0] kl, input logic [255:0] k);
    key_len = kl;
    key     = k;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int c;
    c = 0;
    while ((busy || rk_valid) && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    if (busy || rk_valid) begin
      n_cmp++;
      n_fail++;
      $display("FAIL idle_timeout: still busy after %0d cycles", budget);
    end
    chk("drained", 144'(exp_q.size()), 144'(0));
  endtask

  // Latency-checked run with rk_ready held high.
  task automatic run_kat(input logic [1:0] kl, input logic [255:0] k, input logic [127:0] kat);
    int nk;
    int nr;
    nk = 4 + 2*int'(kl);
    nr = nk + 6;
    model_push(nk, k);
    do_start(kl, k);
    chk("busy_after_start", 144'(busy), 144'(1));
    for (int c = 1; c < 4; c++) begin
      @(posedge clk); #1;
      chk("early_valid", 144'(rk_valid), 144'(0));
    end
    @(posedge clk); #1;
    chk("first_valid", 144'(rk_valid), 144'(1));
    chk("first_idx", 144'(rk_idx), 144'(0));
    chk("first_data", 144'(rk_data), 144'(k[255:128]));
    repeat (4*nr) @(posedge clk);
    #1;
    chk("last_valid", 144'(rk_valid), 144'(1));
    chk("last_idx", 144'(rk_idx), 144'(nr));
    chk("last_flag", 144'(rk_last), 144'(1));
    chk("last_kat", 144'(rk_data), 144'(kat));
    wait_idle(200);
  endtask

  // Consumer ready driver.
  initial begin
    forever begin
      @(posedge clk); #1;
      rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on each handshake and checks stall stability.
  initial begin
    rk_t cur;
    rk_t prev;
    rk_t e;
    bit  prev_stall;
    prev_stall = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        cur = {rk_data, rk_idx, rk_last};
        if (prev_stall)
          chk("stall_hold", 144'({rk_valid, cur}), 144'({1'b1, prev}));
        if (rk_valid && rk_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_key: got idx %0d, expected no key", rk_idx);
          end else begin
            e = exp_q.pop_front();
            chk("rk_data", 144'(rk_data), 144'(e.data));
            chk("rk_idx", 144'(rk_idx), 144'(e.idx));
            chk("rk_last", 144'(rk_last), 144'(e.last));
          end
        end
        prev_stall = rk_valid && !rk_ready;
        prev = cur;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [255:0] k;
    int           c;
    int           kl;
    build_sbox();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 144'(busy), 144'(0));
    chk("rst_err", 144'(err), 144'(0));
    chk("rst_valid", 144'(rk_valid), 144'(0));
    chk("rst_last", 144'(rk_last), 144'(0));
    chk("rst_data", 144'(rk_data), 144'(0));
    chk("rst_idx", 144'(rk_idx), 144'(0));
    chk("rst_rd_key", 144'(rd_key), 144'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // Known-answer runs, low unused key bits randomised.
    k = rkey();
    k[255:128] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    run_kat(2'd0, k, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    k = rkey();
    k[255:64] = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    run_kat(2'd1, k, 128'he98ba06f448c773c8ecc720401002202);
    k = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    run_kat(2'd2, k, 128'hfe4890d1e6188d0b046df344706c631e);

    // Store readback after the AES-256 run.
    rd_idx = 4'd7;
    @(posedge clk); #1;
`ifdef AES_KEY_STORE_EN
    chk("store_idx7", 144'(rd_key), 144'(last_rk[7]));
`else
    chk("store_off", 144'(rd_key), 144'(0));
`endif
    rd_idx = 4'd15;
    @(posedge clk); #1;
    chk("store_idx15", 144'(rd_key), 144'(0));

    // Random backpressure: KAT key then random keys of every length.
    rand_ready = 1'b1;
    k = rkey();
    k[255:128] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    model_push(4, k);
    do_start(2'd0, k);
    wait_idle(2000);
    for (int n = 0; n < 6; n++) begin
      kl = n % 3;
      k = rkey();
      model_push(4 + 2*kl, k);
      do_start(2'(kl), k);
      wait_idle(2000);
    end
    rand_ready = 1'b0;
    @(posedge clk); #1;

    // Illegal key length.
    do_start(2'd3, rkey());
    chk("err_pulse", 144'(err), 144'(1));
    chk("err_busy", 144'(busy), 144'(0));
    @(posedge clk); #1;
    chk("err_clear", 144'(err), 144'(0));

    // Start while busy is ignored.
    k = rkey();
    model_push(8, k);
    do_start(2'd2, k);
    repeat (10) @(posedge clk);
    #1;
    do_start(2'd0, rkey());
    chk("busy_hold", 144'(busy), 144'(1));
    wait_idle(500);

    // Reset at round 5, then a fresh full run.
    k = rkey();
    model_push(4, k);
    do_start(2'd0, k);
    c = 0;
    while (!(rk_valid && rk_idx == 4'd5) && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    if (!(rk_valid && rk_idx == 4'd5)) begin
      n_cmp++;
      n_fail++;
      $display("FAIL round5_timeout: idx %0d, expected 5", rk_idx);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    chk("abort_valid", 144'(rk_valid), 144'(0));
    chk("abort_busy", 144'(busy), 144'(0));
    chk("abort_data", 144'(rk_data), 144'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    k = rkey();
    model_push(6, k);
    do_start(2'd1, k);
    wait_idle(500);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
